// File: rtl/ofm_collector.sv
// ofm_collector
// Captures the two result streams of the CONV engine (pixel p and p+1 of the
// same channel per cycle) into an output feature-map buffer laid out as
// addr = ch*NUM_PIX + pix. It flags completion and protocol errors, and
// provides a registered random-access read port for dumping the results.
//
// Ports
//   clk, rst          system clock (rising edge), synchronous active-high reset
//   in_start          one-cycle pulse: arm collection, latch in_cfg_co / in_relu
//   in_cfg_co         channel count select: 0->8, 1->16, 2->24, 3..7->32
//   in_relu           clamp negative results to zero for this frame
//   in_valid          result pair present (in_data0 = pix, in_data1 = pix+1)
//   in_end_conv       end-of-convolution pulse from the CONV top
//   out_busy          high while collecting
//   out_done          high once the frame ended (full or short)
//   out_err           sticky protocol error, cleared by in_start or rst
//   rd_en, rd_addr    read request
//   rd_data, rd_valid read data one cycle after rd_en
//
// state     | meaning
// S_IDLE    | waiting for in_start, stray in_valid flags an error
// S_COLLECT | storing result pairs, advancing pix/ch
// S_DONE    | frame finished or cut short, waiting for next in_start
module ofm_collector #(
  parameter int LEN_OUT = 25,
  parameter int NUM_PIX = 3721,
  parameter int MAX_CO  = 32,
  parameter int ADDR_W  = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_start,
  input  logic [2:0]         in_cfg_co,
  input  logic               in_relu,
  input  logic               in_valid,
  input  logic [LEN_OUT-1:0] in_data0,
  input  logic [LEN_OUT-1:0] in_data1,
  input  logic               in_end_conv,
  output logic               out_busy,
  output logic               out_done,
  output logic               out_err,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [LEN_OUT-1:0] rd_data,
  output logic               rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PIX_W = $clog2(NUM_PIX + 2);
  localparam int CH_W  = $clog2(MAX_CO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t             state;
  logic [PIX_W-1:0]   pix;
  logic [CH_W-1:0]    ch;
  logic [CH_W-1:0]    co_n;
  logic [ADDR_W-1:0]  base;
  logic               relu_q;

  logic [LEN_OUT-1:0] mem [0:DEPTH-1];

  logic [PIX_W-1:0]   pix_nxt;
  logic [CH_W-1:0]    ch_inc;
  logic               pix_wrap;
  logic               has_d1;
  logic               last_pair;
  logic               accept;
  logic [ADDR_W-1:0]  addr0;
  logic [ADDR_W-1:0]  addr1;
  logic [LEN_OUT-1:0] wd0;
  logic [LEN_OUT-1:0] wd1;
  logic [2:0]         cfg_cl;
  logic [CH_W-1:0]    co_n_new;

  assign pix_nxt   = pix + PIX_W'(2);
  assign ch_inc    = ch + CH_W'(1);
  assign pix_wrap  = (pix_nxt >= PIX_W'(NUM_PIX));
  // Odd NUM_PIX: the last pair of a channel only carries one real pixel.
  assign has_d1    = ((pix + PIX_W'(1)) < PIX_W'(NUM_PIX));
  assign last_pair = pix_wrap && (ch_inc == co_n);
  // Start wins over a coincident in_valid; that data is dropped silently.
  assign accept    = !rst && !in_start && in_valid && (state == S_COLLECT);
  assign addr0     = base + ADDR_W'(pix);
  assign addr1     = addr0 + ADDR_W'(1);
  assign wd0       = (relu_q && in_data0[LEN_OUT-1]) ? '0 : in_data0;
  assign wd1       = (relu_q && in_data1[LEN_OUT-1]) ? '0 : in_data1;

  assign cfg_cl    = (in_cfg_co > 3'd3) ? 3'd3 : in_cfg_co;
  assign co_n_new  = CH_W'({cfg_cl[1:0], 3'b000}) + CH_W'(8);

  // Buffer is deliberately left out of reset so results survive an rst.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[addr0] <= wd0;
      if (has_d1) begin
        mem[addr1] <= wd1;
      end
    end
  end

  // Nonblocking read gives old data on a same-cycle read/write collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pix      <= '0;
      ch       <= '0;
      co_n     <= '0;
      base     <= '0;
      relu_q   <= 1'b0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_err  <= 1'b0;
    end else if (in_start) begin
      state    <= S_COLLECT;
      pix      <= '0;
      ch       <= '0;
      co_n     <= co_n_new;
      base     <= '0;
      relu_q   <= in_relu;
      out_busy <= 1'b1;
      out_done <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (in_valid) begin
            if (pix_wrap) begin
              pix  <= '0;
              ch   <= ch_inc;
              base <= base + ADDR_W'(NUM_PIX);
              if (ch_inc == co_n) begin
                state    <= S_DONE;
                out_busy <= 1'b0;
                out_done <= 1'b1;
              end
            end else begin
              pix <= pix_nxt;
            end
          end
          // end_conv arriving with the final pair is a normal completion.
          if (in_end_conv && !(in_valid && last_pair)) begin
            state    <= S_DONE;
            out_busy <= 1'b0;
            out_done <= 1'b1;
            out_err  <= 1'b1;
          end
        end
        default: begin
          if (in_valid) begin
            out_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_collector.sv
// Testbench for ofm_collector: a small instance (NUM_PIX=5) for directed
// frame, ReLU, error and reset scenarios, plus a default-size instance for
// one full 32-channel frame.
module tb_ofm_collector;

  localparam int LEN = 25;
  localparam int SP  = 5;
  localparam int SA  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic           s_start, s_relu, s_valid, s_end;
  logic [2:0]     s_cfg;
  logic [LEN-1:0] s_d0, s_d1;
  logic           s_busy, s_done, s_err;
  logic           s_rd_en, s_rd_valid;
  logic [SA-1:0]  s_rd_addr;
  logic [LEN-1:0] s_rd_data;

  logic           b_start, b_relu, b_valid, b_end;
  logic [2:0]     b_cfg;
  logic [LEN-1:0] b_d0, b_d1;
  logic           b_busy, b_done, b_err;
  logic           b_rd_en, b_rd_valid;
  logic [16:0]    b_rd_addr;
  logic [LEN-1:0] b_rd_data;

  ofm_collector #(.LEN_OUT(LEN), .NUM_PIX(SP), .MAX_CO(32), .ADDR_W(SA)) u_small (
    .clk(clk), .rst(rst), .in_start(s_start), .in_cfg_co(s_cfg), .in_relu(s_relu),
    .in_valid(s_valid), .in_data0(s_d0), .in_data1(s_d1), .in_end_conv(s_end),
    .out_busy(s_busy), .out_done(s_done), .out_err(s_err),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid)
  );

  ofm_collector u_big (
    .clk(clk), .rst(rst), .in_start(b_start), .in_cfg_co(b_cfg), .in_relu(b_relu),
    .in_valid(b_valid), .in_data0(b_d0), .in_data1(b_d1), .in_end_conv(b_end),
    .out_busy(b_busy), .out_done(b_done), .out_err(b_err),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [LEN-1:0] exp_mem [0:159];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_start_frame(input logic [2:0] cfg, input logic relu);
    s_start = 1'b1;
    s_cfg   = cfg;
    s_relu  = relu;
    step();
    s_start = 1'b0;
  endtask

  // Pair k of a frame: 3 pairs per channel with NUM_PIX=5.
  task automatic s_pair(input int k, input logic [LEN-1:0] d0, input logic [LEN-1:0] d1,
                        input logic relu);
    int c, px;
    s_valid = 1'b1;
    s_d0    = d0;
    s_d1    = d1;
    step();
    s_valid = 1'b0;
    c  = k / 3;
    px = 2 * (k % 3);
    exp_mem[c*SP+px] = (relu && d0[LEN-1]) ? '0 : d0;
    if (px + 1 < SP) exp_mem[c*SP+px+1] = (relu && d1[LEN-1]) ? '0 : d1;
  endtask

  task automatic s_read(input int a, output logic [LEN-1:0] d);
    s_rd_en   = 1'b1;
    s_rd_addr = SA'(a);
    step();
    s_rd_en = 1'b0;
    d = s_rd_data;
  endtask

  task automatic s_check_all(input string tag);
    logic [LEN-1:0] d;
    for (int a = 0; a < 8*SP; a++) begin
      s_read(a, d);
      chk($sformatf("%s[%0d]", tag, a), 32'(d), 32'(exp_mem[a]));
    end
  endtask

  task automatic b_read(input int a, output logic [LEN-1:0] d);
    b_rd_en   = 1'b1;
    b_rd_addr = 17'(a);
    step();
    b_rd_en = 1'b0;
    d = b_rd_data;
  endtask

  initial begin
    logic [LEN-1:0] d;
    logic [LEN-1:0] old;

    rst = 1'b1;
    s_start = 0; s_relu = 0; s_valid = 0; s_end = 0; s_cfg = 0; s_d0 = 0; s_d1 = 0;
    s_rd_en = 0; s_rd_addr = 0;
    b_start = 0; b_relu = 0; b_valid = 0; b_end = 0; b_cfg = 0; b_d0 = 0; b_d1 = 0;
    b_rd_en = 0; b_rd_addr = 0;
    for (int i = 0; i < 160; i++) exp_mem[i] = '0;
    step(); step(); step();
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_err", s_err, 0);
    chk("rst_rd_valid", s_rd_valid, 0);
    chk("rst_rd_data", s_rd_data, 0);
    rst = 1'b0;
    step();

    // Full frame, 8 channels: 24 pairs, data0 = 2k, data1 = 2k+1.
    s_start_frame(3'd0, 1'b0);
    chk("full_busy", s_busy, 1);
    for (int k = 0; k < 24; k++) begin
      s_pair(k, LEN'(2*k), LEN'(2*k+1), 1'b0);
      if (k == 22) chk("full_done_early", s_done, 0);
    end
    chk("full_done", s_done, 1);
    chk("full_busy_low", s_busy, 0);
    chk("full_err", s_err, 0);
    s_read(4, d);
    chk("full_ch0_last", 32'(d), 32'd4);
    chk("full_rd_valid", s_rd_valid, 1);
    s_read(5, d);
    chk("full_ch1_first", 32'(d), 32'd6);
    s_check_all("full");

    // ReLU on and off; each read follows the write by one edge.
    s_start_frame(3'd0, 1'b1);
    s_pair(0, 25'h1FFFFFF, 25'd100, 1'b1);
    s_read(0, d);
    chk("relu_neg", 32'(d), 32'd0);
    s_read(1, d);
    chk("relu_pos", 32'(d), 32'd100);
    s_start_frame(3'd0, 1'b0);
    s_pair(0, 25'h1FFFFFF, 25'd100, 1'b0);
    s_read(0, d);
    chk("norelu_neg", 32'(d), 32'h1FFFFFF);
    s_read(1, d);
    chk("norelu_pos", 32'(d), 32'd100);

    // Short frame: end_conv after 10 pairs; later traffic writes nothing.
    s_start_frame(3'd0, 1'b0);
    for (int k = 0; k < 10; k++) s_pair(k, LEN'(1000+k), LEN'(2000+k), 1'b0);
    chk("short_err_pre", s_err, 0);
    s_end = 1'b1;
    step();
    s_end = 1'b0;
    chk("short_err", s_err, 1);
    chk("short_done", s_done, 1);
    chk("short_busy", s_busy, 0);
    s_valid = 1'b1; s_d0 = 25'd7777; s_d1 = 25'd7778;
    step();
    s_valid = 1'b0;
    s_end = 1'b1;
    step();
    s_end = 1'b0;
    chk("short_err_hold", s_err, 1);
    chk("short_done_hold", s_done, 1);
    s_check_all("short");

    // in_valid in IDLE flags an error and leaves the buffer alone.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("idle_err_clr", s_err, 0);
    chk("idle_done_clr", s_done, 0);
    s_valid = 1'b1; s_d0 = 25'd3333; s_d1 = 25'd3334;
    step();
    s_valid = 1'b0;
    chk("idle_valid_err", s_err, 1);
    s_check_all("idle_valid");

    // Start with coincident valid: data dropped, no error.
    s_start = 1'b1; s_cfg = 3'd0; s_relu = 1'b0;
    s_valid = 1'b1; s_d0 = 25'd4444; s_d1 = 25'd4445;
    step();
    s_start = 1'b0; s_valid = 1'b0;
    chk("startvalid_err", s_err, 0);
    chk("startvalid_busy", s_busy, 1);
    s_read(0, d);
    chk("startvalid_nowrite", 32'(d), 32'(exp_mem[0]));
    s_pair(0, 25'd42, 25'd43, 1'b0);
    s_read(0, d);
    chk("startvalid_addr0", 32'(d), 32'd42);
    s_read(1, d);
    chk("startvalid_addr1", 32'(d), 32'd43);

    // Reset mid-frame, then a full fresh frame.
    s_start_frame(3'd0, 1'b0);
    for (int k = 0; k < 7; k++) s_pair(k, LEN'(3000+k), LEN'(3100+k), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", s_busy, 0);
    chk("midrst_done", s_done, 0);
    chk("midrst_err", s_err, 0);
    s_start_frame(3'd0, 1'b0);
    for (int k = 0; k < 24; k++) begin
      if (k == 0) begin
        old = exp_mem[0];
        s_rd_en = 1'b1;
        s_rd_addr = '0;
      end
      s_pair(k, LEN'(300 + 7*k), LEN'(9000 + 11*k), 1'b0);
      if (k == 0) begin
        s_rd_en = 1'b0;
        chk("rw_collision_old", 32'(s_rd_data), 32'(old));
      end
      if (k == 22) chk("refr_done_early", s_done, 0);
    end
    chk("refr_done", s_done, 1);
    chk("refr_err", s_err, 0);
    s_check_all("refr");

    // cfg_co=5 clamps to 32 channels: not done at 24 pairs, done at 96.
    s_start_frame(3'd5, 1'b0);
    for (int k = 0; k < 96; k++) begin
      s_pair(k, LEN'(k), LEN'(k+500), 1'b0);
      if (k == 23) chk("cfg5_not_done_24", s_done, 0);
      if (k == 94) chk("cfg5_not_done_95", s_done, 0);
    end
    chk("cfg5_done", s_done, 1);
    s_read(31*SP + 4, d);
    chk("cfg5_last", 32'(d), 32'd95);

    // Default-size frame: 32 channels x 1861 pairs.
    b_start = 1'b1; b_cfg = 3'd3; b_relu = 1'b0;
    step();
    b_start = 1'b0;
    for (int k = 0; k < 59552; k++) begin
      b_valid = 1'b1;
      b_d0 = LEN'(k);
      b_d1 = LEN'(k) ^ 25'h155;
      step();
      if (k == 59550) chk("big_done_early", b_done, 0);
    end
    b_valid = 1'b0;
    chk("big_done", b_done, 1);
    chk("big_busy", b_busy, 0);
    chk("big_err", b_err, 0);
    b_read(119071, d);
    chk("big_last_d0", 32'(d), 32'd59551);
    chk("big_rd_valid", b_rd_valid, 1);
    b_read(119070, d);
    chk("big_last_d1", 32'(d), 32'(25'd59550 ^ 25'h155));
    b_read(3720, d);
    chk("big_ch0_tail", 32'(d), 32'd1860);
    b_read(3721, d);
    chk("big_ch1_head", 32'(d), 32'd1861);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
